// File: rtl/wb_mem_responder_if.sv
// Wishbone classic-cycle bus bundle shared by wb_mem_responder and its masters.
// The slave modport receives ADR/DAT_W/SEL/WE/CYC/STB and drives DAT_R/ACK/ERR.
interface wb_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]   adr;
  logic [WB_DATA_WIDTH-1:0]   dat_w;
  logic [WB_DATA_WIDTH-1:0]   dat_r;
  logic [WB_DATA_WIDTH/8-1:0] sel;
  logic                       we;
  logic                       cyc;
  logic                       stb;
  logic                       ack;
  logic                       err;

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );
endinterface

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone classic-cycle slave scratch memory with byte-lane
// writes, a fixed number of wait states, CYC-drop abort and out-of-range
// detection. Storage is never cleared by rst.
//
// Optional feature macro: WB_MEM_RESPONDER_ERR_EN
//   defined   - out-of-range accesses complete with ERR (DAT_R unchanged)
//   undefined - ERR tied low; out-of-range accesses ACK, reads return 0
module wb_mem_responder #(
  parameter int                     WB_ADDR_WIDTH   = 32,
  parameter int                     WB_DATA_WIDTH   = 32,
  parameter int                     MEM_DEPTH_WORDS = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                     WAIT_STATES     = 0
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  s,
  output logic busy
);

  localparam int BL        = WB_DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BL);
  localparam int IDX_W     = $clog2(MEM_DEPTH_WORDS);
  localparam logic [WB_ADDR_WIDTH:0] MEM_BYTES =
    (WB_ADDR_WIDTH+1)'(MEM_DEPTH_WORDS * BL);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // NOTE: the storage array has no reset on purpose - contents must survive
  // rst, and leaving it out keeps the array mappable onto RAM macros.
  logic [WB_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WB_DATA_WIDTH-1:0] dat_w_q, dat_w_d;
  logic [BL-1:0]            sel_q, sel_d;
  logic                     we_q, we_d;
  logic                     in_range_q, in_range_d;
  logic [WB_DATA_WIDTH-1:0] dat_r_q, dat_r_d;

  logic [WB_ADDR_WIDTH-1:0] req_offset;
  logic                     req_in_range;
  logic [IDX_W-1:0]         req_idx;
  logic [WB_DATA_WIDTH-1:0] rd_word;

  // Decode the live bus address: offset from base, range test, word index.
  // Addresses below BASE_ADDR would wrap the subtraction, so they are
  // rejected by the explicit >= test rather than by the size compare.
  always_comb begin
    req_offset   = s.adr - BASE_ADDR;
    req_in_range = (s.adr >= BASE_ADDR) && ({1'b0, req_offset} < MEM_BYTES);
    req_idx      = req_offset[LANE_BITS +: IDX_W];
  end

  // Next-state, request latch and read-data selection.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dat_w_d    = dat_w_q;
    sel_d      = sel_q;
    we_d       = we_q;
    in_range_d = in_range_q;
    dat_r_d    = dat_r_q;

    unique case (state_q)
      ST_IDLE: begin
        if (s.cyc && s.stb) begin
          idx_d      = req_idx;
          dat_w_d    = s.dat_w;
          sel_d      = s.sel;
          we_d       = s.we;
          in_range_d = req_in_range;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!s.cyc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Read data is captured on entry to RESP so DAT_R is valid throughout
    // the RESP cycle and then holds until the next read completes.
    rd_word = mem[idx_d];
    if (state_d == ST_RESP && state_q != ST_RESP && !we_d) begin
      if (in_range_d) begin
        dat_r_d = rd_word;
      end else begin
`ifndef WB_MEM_RESPONDER_ERR_EN
        dat_r_d = '0;
`endif
      end
    end
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      dat_w_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      in_range_q <= 1'b0;
      dat_r_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dat_w_q    <= dat_w_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      in_range_q <= in_range_d;
      dat_r_q    <= dat_r_d;
    end
  end

  // Byte-lane write at the end of the RESP cycle; rst drops a pending write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_RESP && we_q && in_range_q) begin
      for (int b = 0; b < BL; b++) begin
        if (sel_q[b]) begin
          mem[idx_q][8*b +: 8] <= dat_w_q[8*b +: 8];
        end
      end
    end
  end

  assign s.dat_r = dat_r_q;
  assign busy    = (state_q != ST_IDLE);

`ifdef WB_MEM_RESPONDER_ERR_EN
  assign s.ack = (state_q == ST_RESP) &&  in_range_q;
  assign s.err = (state_q == ST_RESP) && !in_range_q;
`else
  assign s.ack = (state_q == ST_RESP);
  assign s.err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: three instances with 0, 3 and 5 wait
// states share one set of request signals; each has its own CYC.
module tb_wb_mem_responder;

`ifdef WB_MEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        cyc_v [3];
  logic        ack_v [3];
  logic        err_v [3];
  logic        busy_v [3];
  logic [31:0] rd_v [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus0 ();
  wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus1 ();
  wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus2 ();

  assign bus0.adr = adr;  assign bus0.dat_w = dat_w;  assign bus0.sel = sel;
  assign bus0.we  = we;   assign bus0.stb   = stb;    assign bus0.cyc = cyc_v[0];
  assign bus1.adr = adr;  assign bus1.dat_w = dat_w;  assign bus1.sel = sel;
  assign bus1.we  = we;   assign bus1.stb   = stb;    assign bus1.cyc = cyc_v[1];
  assign bus2.adr = adr;  assign bus2.dat_w = dat_w;  assign bus2.sel = sel;
  assign bus2.we  = we;   assign bus2.stb   = stb;    assign bus2.cyc = cyc_v[2];

  assign ack_v[0] = bus0.ack;  assign err_v[0] = bus0.err;  assign rd_v[0] = bus0.dat_r;
  assign ack_v[1] = bus1.ack;  assign err_v[1] = bus1.err;  assign rd_v[1] = bus1.dat_r;
  assign ack_v[2] = bus2.ack;  assign err_v[2] = bus2.err;  assign rd_v[2] = bus2.dat_r;

  wb_mem_responder #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH_WORDS(16),
                     .BASE_ADDR(BASE), .WAIT_STATES(0))
    u_ws0 (.clk(clk), .rst(rst), .s(bus0), .busy(busy_v[0]));
  wb_mem_responder #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH_WORDS(16),
                     .BASE_ADDR(BASE), .WAIT_STATES(3))
    u_ws3 (.clk(clk), .rst(rst), .s(bus1), .busy(busy_v[1]));
  wb_mem_responder #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_DEPTH_WORDS(16),
                     .BASE_ADDR(BASE), .WAIT_STATES(5))
    u_ws5 (.clk(clk), .rst(rst), .s(bus2), .busy(busy_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer on instance d. STB is dropped right after the sample edge
  // (it must be ignored from then on); CYC is held until ACK/ERR is seen.
  // lat counts cycles after the sample edge; -1 means no response arrived.
  task automatic bus_op(input int d, input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] dat, input logic [3:0] sl,
                        output int lat, output logic got_err, output logic [31:0] rdata);
    @(negedge clk);
    adr = a; dat_w = dat; sel = sl; we = w; stb = 1'b1; cyc_v[d] = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    lat = -1; got_err = 1'b0; rdata = '0;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (ack_v[d] || err_v[d]) begin
        lat = k; got_err = err_v[d]; rdata = rd_v[d];
        check({tag, "_not_both"}, {31'b0, ack_v[d] & err_v[d]}, 32'd0);
        cyc_v[d] = 1'b0;
      end
    end
    cyc_v[d] = 1'b0;
    @(negedge clk);
    check({tag, "_single_pulse"}, {31'b0, ack_v[d] | err_v[d]}, 32'd0);
    check({tag, "_idle_after"}, {31'b0, busy_v[d]}, 32'd0);
  endtask

  task automatic wr(input int d, input string tag, input logic [31:0] a,
                    input logic [31:0] dat, input logic [3:0] sl, input int exp_lat);
    int lat; logic e; logic [31:0] r;
    bus_op(d, tag, 1'b1, a, dat, sl, lat, e, r);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'b0, e}, 32'd0);
  endtask

  task automatic rd(input int d, input string tag, input logic [31:0] a,
                    input logic [31:0] exp, input int exp_lat);
    int lat; logic e; logic [31:0] r;
    bus_op(d, tag, 1'b0, a, '0, 4'hF, lat, e, r);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, {31'b0, e}, 32'd0);
    check({tag, "_data"}, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int lat; logic e; logic [31:0] r; logic seen;
    cyc_v[0] = 1'b0; cyc_v[1] = 1'b0; cyc_v[2] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, ack_v[0]}, 32'd0);
    check("rst_err", {31'b0, err_v[0]}, 32'd0);
    check("rst_busy0", {31'b0, busy_v[0]}, 32'd0);
    check("rst_busy1", {31'b0, busy_v[1]}, 32'd0);
    check("rst_dat_r", rd_v[0], 32'd0);
    rst = 1'b0;

    // Zero wait states: basic write/read
    wr(0, "w_1004", 32'h1004, 32'hDEADBEEF, 4'hF, 1);
    rd(0, "r_1004", 32'h1004, 32'hDEADBEEF, 1);

    // Byte lanes and SEL=0
    wr(0, "w_1008_full", 32'h1008, 32'h11223344, 4'hF, 1);
    wr(0, "w_1008_lanes", 32'h100A, 32'hAABBCCDD, 4'b0101, 1);
    rd(0, "r_1008_lanes", 32'h1008, 32'h11BB33DD, 1);
    wr(0, "w_1008_sel0", 32'h1008, 32'hFFFFFFFF, 4'h0, 1);
    rd(0, "r_1008_sel0", 32'h1008, 32'h11BB33DD, 1);

    // Three wait states: latency and busy window on a read
    wr(1, "w3_1010", 32'h1010, 32'hCAFEF00D, 4'hF, 4);
    @(negedge clk);
    adr = 32'h1010; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc_v[1] = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("ws3_busy_c%0d", k), {31'b0, busy_v[1]}, {31'b0, k <= 4});
      check($sformatf("ws3_ack_c%0d", k), {31'b0, ack_v[1]}, {31'b0, k == 4});
      if (k == 4) begin
        check("ws3_data", rd_v[1], 32'hCAFEF00D);
        cyc_v[1] = 1'b0;
      end
    end

    // Abort: five wait states, CYC dropped after two wait cycles
    wr(2, "w5_1014", 32'h1014, 32'h01234567, 4'hF, 6);
    @(negedge clk);
    adr = 32'h1014; dat_w = 32'h5A5A5A5A; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc_v[2] = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    check("abort_busy_c1", {31'b0, busy_v[2]}, 32'd1);
    @(negedge clk);
    check("abort_busy_c2", {31'b0, busy_v[2]}, 32'd1);
    cyc_v[2] = 1'b0;
    @(negedge clk);
    check("abort_idle", {31'b0, busy_v[2]}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ack_v[2] || err_v[2]) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_resp", {31'b0, seen}, 32'd0);
    rd(2, "r5_1014", 32'h1014, 32'h01234567, 6);

    // Out of range: below base and one past the end
    wr(0, "w_1000", 32'h1000, 32'h12345678, 4'hF, 1);
    wr(0, "w_103c", 32'h103C, 32'h0BADC0DE, 4'hF, 1);
    rd(0, "r_1004_again", 32'h1004, 32'hDEADBEEF, 1);
    bus_op(0, "oor_w_0ffc", 1'b1, 32'h0FFC, 32'h77777777, 4'hF, lat, e, r);
    check("oor_w_0ffc_lat", 32'(lat), 32'd1);
    check("oor_w_0ffc_err", {31'b0, e}, {31'b0, ERR_EN});
    bus_op(0, "oor_r_1040", 1'b0, 32'h1040, '0, 4'hF, lat, e, r);
    check("oor_r_1040_lat", 32'(lat), 32'd1);
    check("oor_r_1040_err", {31'b0, e}, {31'b0, ERR_EN});
    check("oor_r_1040_data", r, ERR_EN ? 32'hDEADBEEF : 32'd0);
    bus_op(0, "oor_w_1040", 1'b1, 32'h1040, 32'h66666666, 4'hF, lat, e, r);
    check("oor_w_1040_err", {31'b0, e}, {31'b0, ERR_EN});
    rd(0, "r_103c_kept", 32'h103C, 32'h0BADC0DE, 1);
    rd(0, "r_1000_kept", 32'h1000, 32'h12345678, 1);

    // Reset during WAIT of a write on the three-wait-state instance
    @(negedge clk);
    adr = 32'h1010; dat_w = 32'h99999999; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc_v[1] = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    check("rstw_busy_before", {31'b0, busy_v[1]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ack", {31'b0, ack_v[1]}, 32'd0);
    check("rstw_err", {31'b0, err_v[1]}, 32'd0);
    check("rstw_busy", {31'b0, busy_v[1]}, 32'd0);
    check("rstw_dat_r", rd_v[1], 32'd0);
    rst = 1'b0;
    cyc_v[1] = 1'b0;
    rd(1, "r3_1010_after_rst", 32'h1010, 32'hCAFEF00D, 4);
    rd(0, "r_1004_after_rst", 32'h1004, 32'hDEADBEEF, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
